rc_filter_scheduler: RTL and testbench
======================================

Name: rc_filter_scheduler

Overview:
- Time-multiplexes one multiply-accumulate datapath across NUM_CH first-order RC filter channels, each configurable as low-pass or high-pass.
- On each audio_clk_en pulse it latches all channel inputs, then updates the channel states one at a time.
- It publishes all channel outputs together as one coherent set.
- It sits between discrete sound sources (555 VCOs, mixers) and the audio mixer, replacing per-channel RC filter instances to save DSP blocks.

Parameters:
- NUM_CH, 4, number of filter channels (1..8).
- CLOCK_RATE, 1000000, system clock in Hz.
- SAMPLE_RATE, 48000, audio sample rate in Hz. Elaboration error unless 3*NUM_CH+2 <= CLOCK_RATE/SAMPLE_RATE.
- DEFAULT_COEF, 18'h1_0800, reset value of every channel coefficient register.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- audio_clk_en  in  1  one-cycle sample strobe
- in_samples  in  16*NUM_CH  packed signed inputs; channel k is bits [16k+15:16k]
- out_samples  out  16*NUM_CH  packed signed filtered outputs, same packing
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  $clog2(NUM_CH) (min 1)  channel index
- cfg_data  in  18  bit17 bypass, bit16 mode (1 = high-pass), [15:0] alpha, unsigned Q0.16
- busy  out  1  high while a sample pass is in progress
- done  out  1  one-cycle pulse when out_samples updates
- overrun  out  1  sticky; set when audio_clk_en arrives while busy

Behaviour:
- Reset values: out_samples 0, busy 0, done 0, overrun 0, all channel states 0, all coefficient registers DEFAULT_COEF, FSM in IDLE.
- FSM states: IDLE, LOAD, MULT, WRITE, PUBLISH.
  - IDLE: on audio_clk_en, latch in_samples into input buffer, clear channel counter, go to LOAD, set busy.
  - LOAD: fetch x[ch], state[ch] and coef[ch] into datapath registers.
  - MULT: d = x - state (17-bit signed); p = d * {1'b0, alpha} (34-bit signed) registered.
  - WRITE: lp = sat16(state + (p >>> 16)), truncating arithmetic shift. Store state[ch] <= lp. Store result[ch] <= mode ? sat16(x - lp) : lp.
    - If ch == NUM_CH-1, go to PUBLISH; else ch++ and go to LOAD.
  - PUBLISH: out_samples <= result buffer (all channels at once), done = 1 this cycle, busy <= 0, go to IDLE.
- Latency: strobe sampled at edge 0; done high during cycle 3*NUM_CH+1; out_samples valid from that cycle.
- Saturation: sat16 clamps to [-32768, 32767].
- audio_clk_en while busy (LOAD..PUBLISH): ignored, overrun <= 1. Only reset clears overrun.
- Coefficient writes:
  - cfg_we writes coef[cfg_addr] <= cfg_data on any cycle, including mid-pass.
  - A channel uses the value present at its LOAD cycle.
  - Writes to a channel already processed this pass take effect next pass.
  - cfg_addr >= NUM_CH is ignored.
- Reset mid-pass: abandon the pass, no done pulse, all state as reset values. Channel state memory is cleared so there is no DC pop carried over.
- Write to the channel currently in MULT/WRITE: the in-flight computation keeps its loaded coef.

Optional Feature:
- Macro RC_SCHED_BYPASS_EN.
- Defined: coef bit17 = bypass. In WRITE, a bypassed channel sets result[ch] <= x and state[ch] <= x, so the filter tracks the input and resumes without a transient.
- Undefined: bit17 is stored but ignored; every channel always filters. Timing is identical in both builds.

Decomposition:
- Package rc_sched_pkg:
  - SAMPLE_W = 16, COEF_W = 18, ALPHA_W = 16
  - coef field bit indices BYPASS_BIT = 17, MODE_BIT = 16
  - FSM state enum typedef
  - sat16 function
- One sub-module, rc_filter_mac_stage: registered diff/multiply plus combinational shift, add and saturate. Interface: x, state, alpha, mode, bypass in; lp_next and result out.
- The scheduler holds the FSM, counter, buffers and coefficient registers.

Test Plan:
- Step, low-pass: all channels coef 18'h0_8000, x = 10000, two strobes -> outputs 5000 then 7500. done pulses at cycle 3*NUM_CH+1 after each strobe.
- Step, high-pass: ch1 coef 18'h1_8000, x = 10000 -> ch1 outputs 5000 then 2500 while ch0 (low-pass) outputs 5000 then 7500 in the same passes.
- Saturation: high-pass ch0 alpha 0, x = -32768, three strobes, then x = 32767 -> output 32767, never wraps negative.
- Overrun: second audio_clk_en 3 cycles after the first -> overrun = 1, exactly one done pulse, outputs match the single-pass value.
- Mid-pass config and reset:
  - cfg write to ch3 during ch0 processing -> applied in the same pass.
  - reset asserted at cycle 4 -> out_samples 0, busy 0, no done pulse, next pass starts from state 0.
- With RC_SCHED_BYPASS_EN: ch2 coef 18'h2_0800, x = 1234 -> output 1234. Clearing bypass then continues from state 1234 with no step.

Source files
------------

// File: rtl/rc_sched_pkg.sv
// Shared widths, coefficient field positions, scheduler states and the
// 16-bit saturation helper for the time-multiplexed RC filter.
package rc_sched_pkg;

   localparam int SAMPLE_W   = 16;
   localparam int COEF_W     = 18;
   localparam int ALPHA_W    = 16;
   localparam int BYPASS_BIT = 17;
   localparam int MODE_BIT   = 16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_MULT    = 3'd2,
      ST_WRITE   = 3'd3,
      ST_PUBLISH = 3'd4
   } sched_state_t;

   // In range when the top three bits agree; otherwise clamp by sign.
   function automatic logic [15:0] sat16(input logic [17:0] v);
      logic [15:0] r;
      if ((v[17:15] == 3'b000) || (v[17:15] == 3'b111)) begin
         r = v[15:0];
      end else if (v[17]) begin
         r = 16'h8000;
      end else begin
         r = 16'h7fff;
      end
      return r;
   endfunction

endpackage

// File: rtl/rc_filter_mac_stage.sv
// Shared filter datapath: registered (x - state) * alpha, then shift, add and
// saturate. Bypass is honoured only when RC_SCHED_BYPASS_EN is defined.
module rc_filter_mac_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_en,
   input  logic [15:0] i_x,
   input  logic [15:0] i_state,
   input  logic [15:0] i_alpha,
   input  logic        i_mode,
   input  logic        i_bypass,
   output logic [15:0] o_lp_next,
   output logic [15:0] o_result
);
   import rc_sched_pkg::*;

   logic signed [16:0] w_d;
   logic signed [16:0] w_a;
   logic signed [33:0] r_p;
   logic        [17:0] w_sum;
   logic        [17:0] w_hp;
   logic        [15:0] w_lp;

   assign w_d = {i_x[15], i_x} - {i_state[15], i_state};
   assign w_a = {1'b0, i_alpha};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_p <= 34'sd0;
      end else if (i_en) begin
         r_p <= w_d * w_a;
      end else begin
         r_p <= r_p;
      end
   end

   // r_p[33:16] is the floor (arithmetic >>> 16) of the product.
   assign w_sum = {{2{i_state[15]}}, i_state} + r_p[33:16];
   assign w_lp  = sat16(w_sum);
   assign w_hp  = {{2{i_x[15]}}, i_x} - {{2{w_lp[15]}}, w_lp};

`ifdef RC_SCHED_BYPASS_EN
   always_comb begin
      o_lp_next = w_lp;
      o_result  = i_mode ? sat16(w_hp) : w_lp;
      if (i_bypass) begin
         o_lp_next = i_x;
         o_result  = i_x;
      end else begin
         o_lp_next = w_lp;
      end
   end
`else
   logic w_unused_bypass;
   assign w_unused_bypass = i_bypass;

   always_comb begin
      o_lp_next = w_lp;
      o_result  = i_mode ? sat16(w_hp) : w_lp;
   end
`endif

endmodule

// File: rtl/rc_filter_scheduler.sv
// NUM_CH first-order RC filters sharing one MAC; outputs published together.
// Optional per-channel bypass under RC_SCHED_BYPASS_EN.
module rc_filter_scheduler #(
   parameter int          NUM_CH       = 4,
   parameter int          CLOCK_RATE   = 1000000,
   parameter int          SAMPLE_RATE  = 48000,
   parameter logic [17:0] DEFAULT_COEF = 18'h1_0800,
   localparam int         CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   audio_clk_en,
   input  logic [16*NUM_CH-1:0]   in_samples,
   output logic [16*NUM_CH-1:0]   out_samples,
   input  logic                   cfg_we,
   input  logic [CH_W-1:0]        cfg_addr,
   input  logic [17:0]            cfg_data,
   output logic                   busy,
   output logic                   done,
   output logic                   overrun
);
   import rc_sched_pkg::*;

   if ((NUM_CH < 1) || (NUM_CH > 8)) begin : g_bad_num_ch
      $error("rc_filter_scheduler: NUM_CH must be 1..8");
   end
   if ((3 * NUM_CH + 2) > (CLOCK_RATE / SAMPLE_RATE)) begin : g_bad_rate
      $error("rc_filter_scheduler: not enough clocks per sample for NUM_CH");
   end

   sched_state_t          r_fsm;
   sched_state_t          w_fsm_next;
   logic [CH_W-1:0]       r_ch;
   logic [15:0]           r_in_buf [NUM_CH];
   logic [15:0]           r_state  [NUM_CH];
   logic [15:0]           r_result [NUM_CH];
   logic [17:0]           r_coef   [NUM_CH];
   logic [15:0]           r_x;
   logic [15:0]           r_st;
   logic [15:0]           r_alpha;
   logic                  r_mode;
   logic                  r_bypass;
   logic [16*NUM_CH-1:0]  r_out;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_overrun;
   logic                  w_last;
   logic [15:0]           w_lp_next;
   logic [15:0]           w_result;

   assign w_last = (r_ch == CH_W'(NUM_CH - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fsm <= ST_IDLE;
      end else begin
         r_fsm <= w_fsm_next;
      end
   end

   always_comb begin
      w_fsm_next = r_fsm;
      case (r_fsm)
         ST_IDLE:    w_fsm_next = audio_clk_en ? ST_LOAD : ST_IDLE;
         ST_LOAD:    w_fsm_next = ST_MULT;
         ST_MULT:    w_fsm_next = ST_WRITE;
         ST_WRITE:   w_fsm_next = w_last ? ST_PUBLISH : ST_LOAD;
         ST_PUBLISH: w_fsm_next = ST_IDLE;
         default:    w_fsm_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ch      <= '0;
         r_x       <= 16'h0000;
         r_st      <= 16'h0000;
         r_alpha   <= 16'h0000;
         r_mode    <= 1'b0;
         r_bypass  <= 1'b0;
         r_out     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_overrun <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            r_in_buf[k] <= 16'h0000;
            r_state[k]  <= 16'h0000;
            r_result[k] <= 16'h0000;
            r_coef[k]   <= DEFAULT_COEF;
         end
      end else begin
         case (r_fsm)
            ST_IDLE: begin
               if (audio_clk_en) begin
                  for (int k = 0; k < NUM_CH; k++) begin
                     r_in_buf[k] <= in_samples[16*k +: 16];
                  end
                  r_ch   <= '0;
                  r_busy <= 1'b1;
               end
            end
            ST_LOAD: begin
               r_x      <= r_in_buf[r_ch];
               r_st     <= r_state[r_ch];
               r_alpha  <= r_coef[r_ch][15:0];
               r_mode   <= r_coef[r_ch][MODE_BIT];
               r_bypass <= r_coef[r_ch][BYPASS_BIT];
            end
            ST_WRITE: begin
               r_state[r_ch]  <= w_lp_next;
               r_result[r_ch] <= w_result;
               if (!w_last) begin
                  r_ch <= r_ch + CH_W'(1);
               end
            end
            ST_PUBLISH: begin
               for (int k = 0; k < NUM_CH; k++) begin
                  r_out[16*k +: 16] <= r_result[k];
               end
               r_busy <= 1'b0;
            end
            default: begin
               r_busy <= 1'b0;
            end
         endcase
         r_done    <= (r_fsm == ST_PUBLISH);
         r_overrun <= r_overrun | (audio_clk_en && (r_fsm != ST_IDLE));
         // A write landing on the LOAD edge is seen by the next pass only.
         if (cfg_we && (32'(cfg_addr) < NUM_CH)) begin
            r_coef[cfg_addr] <= cfg_data;
         end
      end
   end

   rc_filter_mac_stage u_mac (
      .clk       (clk),
      .reset     (reset),
      .i_en      (r_fsm == ST_MULT),
      .i_x       (r_x),
      .i_state   (r_st),
      .i_alpha   (r_alpha),
      .i_mode    (r_mode),
      .i_bypass  (r_bypass),
      .o_lp_next (w_lp_next),
      .o_result  (w_result)
   );

   assign out_samples = r_out;
   assign busy        = r_busy;
   assign done        = r_done;
   assign overrun     = r_overrun;

endmodule

// File: tb/tb_rc_filter_scheduler.sv
// Directed self-checking bench for rc_filter_scheduler (NUM_CH = 4).
module tb_rc_filter_scheduler;

   localparam int NUM_CH = 4;
   localparam int LAT    = 3 * NUM_CH + 1;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  audio_clk_en;
   logic [16*NUM_CH-1:0]  in_samples;
   logic [16*NUM_CH-1:0]  out_samples;
   logic                  cfg_we;
   logic [1:0]            cfg_addr;
   logic [17:0]           cfg_data;
   logic                  busy;
   logic                  done;
   logic                  overrun;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rc_filter_scheduler #(.NUM_CH(NUM_CH)) dut (
      .clk          (clk),
      .reset        (reset),
      .audio_clk_en (audio_clk_en),
      .in_samples   (in_samples),
      .out_samples  (out_samples),
      .cfg_we       (cfg_we),
      .cfg_addr     (cfg_addr),
      .cfg_data     (cfg_data),
      .busy         (busy),
      .done         (done),
      .overrun      (overrun)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1; audio_clk_en = 1'b0; cfg_we = 1'b0;
      cfg_addr = 2'd0; cfg_data = 18'h0; in_samples = '0;
      tick; tick;
      reset = 1'b0;
   endtask

   task automatic set_coef(input int ch, input logic [17:0] d);
      cfg_we = 1'b1; cfg_addr = 2'(ch); cfg_data = d;
      tick;
      cfg_we = 1'b0;
   endtask

   task automatic set_x(input int x0, input int x1, input int x2, input int x3);
      in_samples = {16'(x3), 16'(x2), 16'(x1), 16'(x0)};
   endtask

   // Strobe once, then wait (bounded) for done; lat counts edges after the strobe edge.
   task automatic run_pass(output int lat);
      audio_clk_en = 1'b1;
      tick;
      audio_clk_en = 1'b0;
      lat = 0;
      while ((done !== 1'b1) && (lat < 100)) begin
         tick;
         lat++;
      end
   endtask

   function automatic logic [15:0] ch_out(input int k);
      return out_samples[16*k +: 16];
   endfunction

   task automatic test_reset;
      do_reset;
      checks++; if (out_samples !== '0) begin errors++; $display("FAIL reset_out got %h exp 0", out_samples); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
   endtask

   task automatic test_lowpass_step;
      int lat;
      do_reset;
      for (int k = 0; k < NUM_CH; k++) set_coef(k, 18'h0_8000);
      set_x(10000, 10000, 10000, 10000);
      run_pass(lat);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL lp_latency1 got %0d exp %0d", lat, LAT); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lp_busy_at_done got %b exp 0", busy); end
      for (int k = 0; k < NUM_CH; k++) begin
         checks++;
         if (ch_out(k) !== 16'(5000)) begin errors++; $display("FAIL lp_pass1_ch%0d got %0d exp 5000", k, $signed(ch_out(k))); end
      end
      tick;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL lp_done_width got %b exp 0", done); end
      run_pass(lat);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL lp_latency2 got %0d exp %0d", lat, LAT); end
      for (int k = 0; k < NUM_CH; k++) begin
         checks++;
         if (ch_out(k) !== 16'(7500)) begin errors++; $display("FAIL lp_pass2_ch%0d got %0d exp 7500", k, $signed(ch_out(k))); end
      end
   endtask

   // ch0 LP, ch1 HP, ch2 LP with negative input (floor shift), ch3 reset-default coef.
   task automatic test_highpass_mix;
      int lat;
      int e1 [4] = '{5000, 5000, -5001, 9688};
      int e2 [4] = '{7500, 2500, -7501, 9386};
      do_reset;
      set_coef(0, 18'h0_8000);
      set_coef(1, 18'h1_8000);
      set_coef(2, 18'h0_8000);
      set_x(10000, 10000, -10001, 10000);
      run_pass(lat);
      for (int k = 0; k < NUM_CH; k++) begin
         checks++;
         if (ch_out(k) !== 16'(e1[k])) begin errors++; $display("FAIL mix_pass1_ch%0d got %0d exp %0d", k, $signed(ch_out(k)), e1[k]); end
      end
      run_pass(lat);
      for (int k = 0; k < NUM_CH; k++) begin
         checks++;
         if (ch_out(k) !== 16'(e2[k])) begin errors++; $display("FAIL mix_pass2_ch%0d got %0d exp %0d", k, $signed(ch_out(k)), e2[k]); end
      end
   endtask

   task automatic test_saturation;
      int lat;
      int e1 [3] = '{-32768, 0, -32768};
      int e2 [3] = '{32767, 32767, 32766};
      do_reset;
      set_coef(0, 18'h1_0000);
      set_coef(1, 18'h1_FFFF);
      set_coef(2, 18'h0_FFFF);
      set_x(-32768, -32768, -32768, 0);
      for (int p = 0; p < 3; p++) begin
         run_pass(lat);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (ch_out(k) !== 16'(e1[k])) begin errors++; $display("FAIL sat_neg_p%0d_ch%0d got %0d exp %0d", p, k, $signed(ch_out(k)), e1[k]); end
         end
      end
      set_coef(1, 18'h1_0000);
      set_x(32767, 32767, 32767, 0);
      run_pass(lat);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (ch_out(k) !== 16'(e2[k])) begin errors++; $display("FAIL sat_pos_ch%0d got %0d exp %0d", k, $signed(ch_out(k)), e2[k]); end
      end
   endtask

   task automatic test_overrun;
      int n_done;
      do_reset;
      for (int k = 0; k < NUM_CH; k++) set_coef(k, 18'h0_8000);
      set_x(10000, 10000, 10000, 10000);
      audio_clk_en = 1'b1; tick; audio_clk_en = 1'b0;
      tick; tick;
      audio_clk_en = 1'b1; tick; audio_clk_en = 1'b0;
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         tick;
         if (done === 1'b1) n_done++;
      end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", overrun); end
      checks++; if (n_done !== 1) begin errors++; $display("FAIL ovr_done_count got %0d exp 1", n_done); end
      for (int k = 0; k < NUM_CH; k++) begin
         checks++;
         if (ch_out(k) !== 16'(5000)) begin errors++; $display("FAIL ovr_out_ch%0d got %0d exp 5000", k, $signed(ch_out(k))); end
      end
   endtask

   // ch0 rewritten while in flight (keeps loaded coef); ch3 rewritten before its LOAD.
   task automatic test_midpass_cfg;
      int n;
      int lat;
      int e2 [4] = '{5000, 7500, 7500, 7500};
      do_reset;
      for (int k = 0; k < 3; k++) set_coef(k, 18'h0_8000);
      set_coef(3, 18'h0_0000);
      set_x(10000, 10000, 10000, 10000);
      audio_clk_en = 1'b1; tick; audio_clk_en = 1'b0;
      tick;
      cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 18'h0_0000;
      tick;
      cfg_addr = 2'd3; cfg_data = 18'h0_8000;
      tick;
      cfg_we = 1'b0;
      n = 3;
      while ((done !== 1'b1) && (n < 100)) begin
         tick;
         n++;
      end
      checks++; if (n !== LAT) begin errors++; $display("FAIL cfg_latency got %0d exp %0d", n, LAT); end
      for (int k = 0; k < NUM_CH; k++) begin
         checks++;
         if (ch_out(k) !== 16'(5000)) begin errors++; $display("FAIL cfg_pass1_ch%0d got %0d exp 5000", k, $signed(ch_out(k))); end
      end
      run_pass(lat);
      for (int k = 0; k < NUM_CH; k++) begin
         checks++;
         if (ch_out(k) !== 16'(e2[k])) begin errors++; $display("FAIL cfg_pass2_ch%0d got %0d exp %0d", k, $signed(ch_out(k)), e2[k]); end
      end
   endtask

   task automatic test_reset_midpass;
      int lat;
      int n_done;
      do_reset;
      for (int k = 0; k < NUM_CH; k++) set_coef(k, 18'h0_8000);
      set_x(10000, 10000, 10000, 10000);
      run_pass(lat);
      audio_clk_en = 1'b1; tick; audio_clk_en = 1'b0;
      tick; tick; tick;
      reset = 1'b1; tick; reset = 1'b0;
      checks++; if (out_samples !== '0) begin errors++; $display("FAIL rst_mid_out got %h exp 0", out_samples); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
      n_done = 0;
      for (int i = 0; i < 30; i++) begin
         tick;
         if (done === 1'b1) n_done++;
      end
      checks++; if (n_done !== 0) begin errors++; $display("FAIL rst_mid_done got %0d exp 0", n_done); end
      for (int k = 0; k < NUM_CH; k++) set_coef(k, 18'h0_8000);
      run_pass(lat);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL rst_mid_latency got %0d exp %0d", lat, LAT); end
      for (int k = 0; k < NUM_CH; k++) begin
         checks++;
         if (ch_out(k) !== 16'(5000)) begin errors++; $display("FAIL rst_mid_ch%0d got %0d exp 5000", k, $signed(ch_out(k))); end
      end
   endtask

`ifdef RC_SCHED_BYPASS_EN
   task automatic test_bypass;
      int lat;
      do_reset;
      set_coef(2, 18'h2_0800);
      set_x(0, 0, 1234, 0);
      run_pass(lat);
      checks++; if (ch_out(2) !== 16'(1234)) begin errors++; $display("FAIL byp_on got %0d exp 1234", $signed(ch_out(2))); end
      set_coef(2, 18'h0_0800);
      run_pass(lat);
      checks++; if (ch_out(2) !== 16'(1234)) begin errors++; $display("FAIL byp_off got %0d exp 1234", $signed(ch_out(2))); end
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_lowpass_step;
      test_highpass_mix;
      test_saturation;
      test_overrun;
      test_midpass_cfg;
      test_reset_midpass;
`ifdef RC_SCHED_BYPASS_EN
      test_bypass;
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
